// File: rtl/tnn_sort_wave_ctrl.sv
// Wave sequencer for the temporal bitonic sorter: rest the lines, open a timing window,
// timestamp each output's 1->0 edge and hand the results downstream over valid/ready.
module tnn_sort_wave_ctrl #(
  parameter int unsigned N      = 4,
  parameter int unsigned TW     = 4,
  parameter int unsigned WINDOW = 8,
  parameter int unsigned REST   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    sort_in,
  output logic            rest_n,
  output logic            wave_en,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*TW-1:0] t_out,
  output logic [N-1:0]    fired,
  output logic            order_err
);

  localparam int unsigned RW = (REST > 1) ? $clog2(REST) : 1;
  localparam logic [TW-1:0] WinLast = TW'(WINDOW - 1);
  localparam logic [TW-1:0] NoSpike = TW'(WINDOW);
  localparam logic [RW-1:0] RestLast = RW'(REST - 1);

  typedef enum logic [1:0] {StIdle, StRest, StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [N-1:0]    s_q;
  logic [N-1:0]    fired_q, fired_d;
  logic [N*TW-1:0] t_q, t_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      s_q     <= '1;
      fired_q <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      s_q     <= sort_in;
      fired_q <= fired_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    tcnt_d  = tcnt_q;
    fired_d = fired_q;
    t_d     = t_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRest;
          rcnt_d  = '0;
          tcnt_d  = '0;
          fired_d = '0;
          t_d     = '0;
        end
      end
      StRest: begin
        if (rcnt_q == RestLast) state_d = StRun;
        else                    rcnt_d  = rcnt_q + 1'b1;
      end
      StRun: begin
        for (int i = 0; i < N; i++) begin
          if (!s_q[i] && !fired_q[i]) begin
            fired_d[i]        = 1'b1;
            t_d[i*TW +: TW]   = tcnt_q;
          end
        end
        tcnt_d = tcnt_q + 1'b1;
        if (tcnt_q == WinLast || &fired_d) begin
          state_d = StHold;
          // Lines that never fired carry the no-spike code downstream.
          for (int i = 0; i < N; i++) begin
            if (!fired_d[i]) t_d[i*TW +: TW] = NoSpike;
          end
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    order_err = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (fired_q[i] && !fired_q[i-1]) order_err = 1'b1;
      if (fired_q[i] && fired_q[i-1] && (t_q[i*TW +: TW] < t_q[(i-1)*TW +: TW])) begin
        order_err = 1'b1;
      end
    end
  end

  assign rest_n    = (state_q != StRest);
  assign wave_en   = (state_q == StRun);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StHold);
  assign t_out     = t_q;
  assign fired     = fired_q;

endmodule

// File: tb/tb_tnn_sort_wave_ctrl.sv
// Directed bench for tnn_sort_wave_ctrl (N=4, TW=4, WINDOW=8, REST=2).
module tb_tnn_sort_wave_ctrl;

  localparam int N = 4;
  localparam int TW = 4;
  localparam int REST = 2;
  localparam int NV = -1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  sort_in = '1;
  logic          rest_n, wave_en, busy, out_valid;
  logic          out_ready = 1'b1;
  logic [N*TW-1:0] t_out;
  logic [N-1:0]  fired;
  logic          order_err;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          fall [4];
    logic [15:0] t;
    logic [3:0]  fired;
    logic        err;
    int          run;
  } vec_t;

  vec_t vecs [8];

  tnn_sort_wave_ctrl #(.N(4), .TW(4), .WINDOW(8), .REST(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sort_in   (sort_in),
    .rest_n    (rest_n),
    .wave_en   (wave_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .t_out     (t_out),
    .fired     (fired),
    .order_err (order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkvec(input int f0, input int f1, input int f2, input int f3,
                                 input logic [15:0] t, input logic [3:0] fd, input logic e,
                                 input int run);
    vec_t v;
    v.fall[0] = f0; v.fall[1] = f1; v.fall[2] = f2; v.fall[3] = f3;
    v.t = t; v.fired = fd; v.err = e; v.run = run;
    return v;
  endfunction

  task automatic drive_lines(input vec_t v, input int c);
    for (int i = 0; i < N; i++) begin
      // Low on sort_in in cycle c is visible to the window one cycle later.
      sort_in[i] = !(v.fall[i] >= 0 && c >= REST + v.fall[i] - 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rest_n"}, {31'd0, rest_n}, 32'd1);
    check({tag, "_wave_en"}, {31'd0, wave_en}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_t_out"}, {16'd0, t_out}, 32'd0);
    check({tag, "_fired"}, {28'd0, fired}, 32'd0);
    check({tag, "_order_err"}, {31'd0, order_err}, 32'd0);
  endtask

  task automatic run_wave(input vec_t v, input int stall, input string tag);
    int c;
    int nrest;
    int nrun;
    out_ready = (stall == 0);
    sort_in = '1;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    c = 0; nrest = 0; nrun = 0;
    while (!out_valid && c < 40) begin
      if (!rest_n) nrest++;
      if (wave_en) nrun++;
      drive_lines(v, c);
      step();
      c++;
    end
    check({tag, "_valid_seen"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_rest_len"}, nrest, REST);
    check({tag, "_run_len"}, nrun, v.run);
    check({tag, "_t_out"}, {16'd0, t_out}, {16'd0, v.t});
    check({tag, "_fired"}, {28'd0, fired}, {28'd0, v.fired});
    check({tag, "_order_err"}, {31'd0, order_err}, {31'd0, v.err});
    check({tag, "_hold_wave_en"}, {31'd0, wave_en}, 32'd0);
    for (int k = 0; k < stall; k++) begin
      start = (k == 2);
      drive_lines(v, c + k);
      step();
      check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_stall_t_out"}, {16'd0, t_out}, {16'd0, v.t});
    end
    out_ready = 1'b1;
    // A start presented in the accepting cycle must be dropped.
    start = (stall != 0);
    step();
    start = 1'b0;
    sort_in = '1;
    check({tag, "_accept_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_accept_busy"}, {31'd0, busy}, 32'd0);
    step();
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_t_out"}, {16'd0, t_out}, {16'd0, v.t});
    check({tag, "_idle_fired"}, {28'd0, fired}, {28'd0, v.fired});
  endtask

  initial begin
    vecs[0] = mkvec(1, 3, 3, 6, 16'h6331, 4'hF, 1'b0, 7);
    vecs[1] = mkvec(2, 5, NV, NV, 16'h8852, 4'h3, 1'b0, 8);
    vecs[2] = mkvec(4, 2, NV, NV, 16'h8824, 4'h3, 1'b1, 8);
    vecs[3] = mkvec(NV, 2, NV, NV, 16'h8828, 4'h2, 1'b1, 8);
    vecs[4] = mkvec(0, 0, 0, 0, 16'h0000, 4'hF, 1'b0, 1);
    vecs[5] = mkvec(7, 7, 7, 7, 16'h7777, 4'hF, 1'b0, 8);
    vecs[6] = mkvec(8, 8, 8, 8, 16'h8888, 4'h0, 1'b0, 8);
    vecs[7] = mkvec(0, 1, 1, 2, 16'h2110, 4'hF, 1'b0, 3);

    #3;
    check_reset_vals("por");
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_wave(vecs[i], 0, $sformatf("vec%0d", i));
    end

    run_wave(vecs[0], 5, "stall");

    // Reset mid-window: line 0 has already fired when reset hits at t=3.
    sort_in = '1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < REST + 3; c++) begin
      drive_lines(vecs[0], c);
      step();
    end
    check("mid_wave_en", {31'd0, wave_en}, 32'd1);
    check("mid_fired", {28'd0, fired}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    step();
    rst_n = 1'b1;
    sort_in = '1;
    step();
    run_wave(vecs[1], 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
